// File: rtl/seven_seg_pkg.sv
// Shared types and widths for the seven-segment scan controller.
// Imported by the scan controller and its dwell counter.
package seven_seg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      DRIVE
   } state_t;

   localparam int NIB_W = 4;
   localparam int SEG_W = 7;

endpackage

// File: rtl/seven_seg_dwell_counter.sv
// Wrap counter timing how long each digit is driven.
// Flags the final cycle of the dwell period.
module seven_seg_dwell_counter #(
   parameter int p_dwell = 3,
   localparam int CW = (p_dwell > 1) ? $clog2(p_dwell) : 1
) (
   input  logic          clk,
   input  logic          clear,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          last
);

   localparam logic [CW-1:0] LAST_CNT = CW'(p_dwell - 1);

   // clear wins over inc so every dwell starts from zero
   always_ff @(posedge clk) begin
      if (clear) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan of p_ndigits digits through one shared decoder.
// New values are double-buffered and only shown from a frame boundary.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int p_ndigits = 4,
   parameter int p_dwell   = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       load_val,
   input  logic [NIB_W*p_ndigits-1:0] load_data,
   output logic [NIB_W-1:0]           dec_in,
   input  logic [SEG_W-1:0]           dec_seg,
   output logic [SEG_W-1:0]           seg,
   output logic [p_ndigits-1:0]       digit_en,
   output logic                       frame_done
);

   localparam int DW = NIB_W * p_ndigits;
   localparam int IW = (p_ndigits > 1) ? $clog2(p_ndigits) : 1;
   localparam int CW = (p_dwell > 1) ? $clog2(p_dwell) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(p_ndigits - 1);

   state_t          state;
   logic [DW-1:0]   active;
   logic [DW-1:0]   shadow;
   logic            pend;
   logic [IW-1:0]   idx;
   logic [CW-1:0]   cnt;
   logic            last;
   logic            in_drive;
   logic            final_cyc;
   logic            commit;
   logic            cnt_clr;

   assign in_drive  = (state == DRIVE);
   assign final_cyc = in_drive && last && (idx == LAST_IDX);
   assign commit    = en && ((state == IDLE) || final_cyc);
   assign cnt_clr   = rst || !en || !in_drive || last;

   seven_seg_dwell_counter #(
      .p_dwell (p_dwell)
   ) u_dwell (
      .clk   (clk),
      .clear (cnt_clr),
      .inc   (in_drive),
      .cnt   (cnt),
      .last  (last)
   );

   // scan sequencing plus shadow/active buffering of the display value
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         active <= '0;
         shadow <= '0;
         pend   <= 1'b0;
         idx    <= '0;
      end else begin
         if (load_val) begin
            shadow <= load_data;
            pend   <= 1'b1;
         end
         if (commit) begin
            active <= load_val ? load_data : shadow;
            pend   <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (en) begin
                  state <= BLANK;
                  idx   <= '0;
               end
            end
            BLANK: begin
               if (!en) begin
                  state <= IDLE;
                  idx   <= '0;
               end else begin
                  state <= DRIVE;
               end
            end
            DRIVE: begin
               if (!en) begin
                  state <= IDLE;
                  idx   <= '0;
               end else if (last) begin
                  state <= BLANK;
                  idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

   assign dec_in     = (state == IDLE) ? '0
                     : active[int'(idx)*NIB_W +: NIB_W];
   assign seg        = in_drive ? dec_seg : '0;
   assign digit_en   = in_drive ? (p_ndigits'(1) << idx) : '0;
   assign frame_done = final_cyc;

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of p_ndigits common-select seven-segment digits that share one binary-to-seven-seg decoder instance.
- Holds a p_ndigits×4-bit display value and sequences one nibble at a time into the shared decoder's input.
- Drives the decoder's segment output plus a one-hot digit enable to the board.
- Double-buffers loads so a new value only takes effect on a frame boundary, which prevents display tearing.

Parameters:
p_ndigits, 4, number of digits scanned; digit 0 = least-significant nibble
p_dwell, 3, cycles each digit is driven per frame (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
en  input  1  scan enable; low blanks display and aborts frame
load_val  input  1  load strobe; always accepted (no ready)
load_data  input  4*p_ndigits  new display value
dec_in  output  4  nibble to shared decoder input
dec_seg  input  7  segment pattern returned by shared decoder (combinational)
seg  output  7  segment drive to board
digit_en  output  p_ndigits  one-hot active-high digit select
frame_done  output  1  one-cycle pulse on last DRIVE cycle of final digit

Behaviour:
- Registers: active (4*p_ndigits), shadow (4*p_ndigits), pend (1), idx ($clog2(p_ndigits)), cnt ($clog2(p_dwell)), state.
- Reset (rst sampled high at posedge; overrides all other inputs, including a mid-frame reset):
  - state=IDLE; active, shadow, pend, idx and cnt all 0.
  - Outputs: digit_en=0, seg=0, dec_in=0, frame_done=0.
- Load:
  - load_val=1 gives shadow<=load_data and pend<=1.
  - Back-to-back loads: the last one wins.
- Commit: active<=shadow, pend<=0. It happens only on a frame boundary:
  - on the IDLE->BLANK transition, or
  - on the final DRIVE cycle of digit p_ndigits-1.
- Simultaneous load_val and commit in the same cycle: load_data bypasses directly into active, and pend ends 0.
- States:
  - IDLE:
    - digit_en=0, seg=0, dec_in=0.
    - If en: go to BLANK with idx=0 and cnt=0, and commit if pend.
  - BLANK (exactly 1 cycle, anti-ghosting gap):
    - digit_en=0, seg=0, dec_in=active[4*idx+:4] so the decoder settles.
    - Next state DRIVE, cnt=0.
  - DRIVE (p_dwell cycles):
    - digit_en=1<<idx, dec_in=active[4*idx+:4], seg=dec_seg.
    - cnt increments each cycle. At cnt==p_dwell-1:
      - If idx==p_ndigits-1: frame_done=1 this cycle, idx<=0, commit.
      - Otherwise: idx<=idx+1.
      - Next state BLANK, with cnt<=0.
- en low in BLANK or DRIVE: next state IDLE, idx=0, cnt=0. No frame_done, no commit. Pending load is retained for the next start.
- Frame length is p_ndigits*(1+p_dwell) cycles; 16 with the defaults.
- All outputs are combinational functions of registered state and dec_seg. There is no combinational path from load_* to any output.
- At most one digit_en bit is ever high. digit_en and seg are both zero whenever not in DRIVE.

Decomposition:
- Shared package seven_seg_pkg holds:
  - the state enum type (IDLE, BLANK, DRIVE);
  - a nibble width constant (4);
  - a segment width constant (7).
- Natural sub-module: seven_seg_dwell_counter, a parameterised wrap counter that produces cnt and a last-cycle flag. Its inputs are clear and inc.
- The decoder itself is instantiated one level up, not inside this block.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, en=0 for 5 cycles -> digit_en=0000, seg=0, frame_done=0 throughout.
- Basic scan: load 0x1234, then en=1 from the next cycle, with the real decoder attached. Required sequence:
  - BLANK with dec_in=4;
  - 3 cycles of digit_en=0001, seg=decode(4);
  - BLANK with dec_in=3;
  - 0010 ×3 ... then 1000 ×3 with dec_in=1;
  - frame_done on cycle 16 after start, then the scan repeats from digit 0.
- Tear-free update: load 0xABCD while digit 1 is being driven -> digits 1–3 still show 3,2,1. The next frame starts with dec_in=D.
- Bypass: load 0x00F0 on the exact frame_done cycle -> the next frame shows digit 1 = F and pend=0. A prior pending value is discarded.
- Abort: deassert en during digit 2 DRIVE -> next cycle digit_en=0, no frame_done. Re-enable -> restarts at BLANK, digit 0.
- Mid-frame reset: rst=1 during digit 3 DRIVE with en=1 -> next cycle all outputs 0 and active=0. With en still high after rst drops, scan restarts showing 0000.
